enc_frame_packer: RTL and testbench

Downstream consumer of the dual-encoder SPI reader. It captures each pair of encoder position words on a sample strobe and buffers them in a small FIFO. Each buffered pair is serialised into a fixed 7-byte frame with header, sequence number and checksum. Frames are emitted over a valid/ready byte interface to the host UART transmitter.

---
 rtl/enc_frame_packer.sv | 211 +++++++++++++++++++++
 tb/tb_enc_frame_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_frame_packer.sv
// Sample-pair FIFO with occupancy count.
// Latency: a pushed entry is at the head one cycle after the push.
// Backpressure: push is taken when not full or when a pop happens in the same cycle; otherwise it is ignored.
module enc_pair_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                   core_clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  logic [W-1:0]           wr_dat,
    input  logic                   pop,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_dat  = mem[rd_ptr];

    // When full, the write slot is the head being popped; the read completes before the edge.
    always_ff @(posedge core_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// Packs buffered encoder pairs into 7-byte frames: header, seq, enc1 hi/lo, enc2 hi/lo, xor checksum.
// Latency: strobe in cycle c into an idle packer gives the header on tx_data in cycle c+2.
// Backpressure: tx_data holds while tx_ready is low; a full FIFO drops new samples and counts them.
module enc_frame_packer #(
    parameter int         DW         = 13,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input  logic                        CLK_10MHZ,
    input  logic                        RST_N,
    input  logic                        sample_valid,
    input  logic [DW-1:0]               enc1_data,
    input  logic [DW-1:0]               enc2_data,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  drop_cnt
);
    localparam int EW = 8 + 2*DW;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt, idx_inc;
    logic [7:0]    seq;
    logic [EW-1:0] fifo_wr_dat, fifo_rd_dat;
    logic          fifo_empty, fifo_full, pop, drop;
    logic [7:0]    head_seq, head_csum;
    logic [15:0]   head_e1, head_e2;
    logic [7:0]    frm_seq, frm_csum;
    logic [15:0]   frm_e1, frm_e2;
    logic [7:0]    next_byte, tx_data_nxt;
    logic          tx_valid_nxt;

    assign fifo_wr_dat = {seq, enc1_data, enc2_data};
    assign head_seq    = fifo_rd_dat[EW-1 -: 8];
    assign head_e1     = 16'(fifo_rd_dat[2*DW-1 -: DW]);
    assign head_e2     = 16'(fifo_rd_dat[DW-1:0]);
    assign head_csum   = head_seq ^ head_e1[15:8] ^ head_e1[7:0] ^ head_e2[15:8] ^ head_e2[7:0];
    assign drop        = sample_valid && fifo_full && !pop;
    assign idx_inc     = idx + 3'd1;
    assign busy        = (state != IDLE) || (fifo_level != '0);

    enc_pair_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (CLK_10MHZ),
        .arst_n   (RST_N),
        .push     (sample_valid),
        .wr_dat   (fifo_wr_dat),
        .pop      (pop),
        .rd_dat   (fifo_rd_dat),
        .level    (fifo_level),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Every strobe consumes a sequence number so drops show up as gaps at the host.
    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            seq      <= '0;
            drop_cnt <= '0;
        end else begin
            if (sample_valid) begin
                seq <= seq + 8'd1;
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            frm_seq  <= '0;
            frm_e1   <= '0;
            frm_e2   <= '0;
            frm_csum <= '0;
        end else if (pop) begin
            frm_seq  <= head_seq;
            frm_e1   <= head_e1;
            frm_e2   <= head_e2;
            frm_csum <= head_csum;
        end
    end

    always_comb begin
        next_byte = HEADER;
        case (idx_inc)
            3'd1:    next_byte = frm_seq;
            3'd2:    next_byte = frm_e1[15:8];
            3'd3:    next_byte = frm_e1[7:0];
            3'd4:    next_byte = frm_e2[15:8];
            3'd5:    next_byte = frm_e2[7:0];
            3'd6:    next_byte = frm_csum;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        pop          = 1'b0;
        tx_valid_nxt = tx_valid;
        tx_data_nxt  = tx_data;
        case (state)
            IDLE: begin
                tx_valid_nxt = 1'b0;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    idx_nxt      = 3'd0;
                    state_nxt    = SEND;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = HEADER;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (idx == 3'd6) begin
                        // Reload straight from the FIFO so consecutive frames have no valid gap.
                        if (!fifo_empty) begin
                            pop         = 1'b1;
                            idx_nxt     = 3'd0;
                            tx_data_nxt = HEADER;
                        end else begin
                            state_nxt    = IDLE;
                            tx_valid_nxt = 1'b0;
                        end
                    end else begin
                        idx_nxt     = idx_inc;
                        tx_data_nxt = next_byte;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            tx_valid <= tx_valid_nxt;
            tx_data  <= tx_data_nxt;
        end
    end
endmodule

// File: tb/tb_enc_frame_packer.sv
// Bench for enc_frame_packer: directed scenarios plus a randomized stream checked against a frame-level model.
module tb_enc_frame_packer;
    localparam int         DW     = 13;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] HEADER = 8'hA5;

    logic          clk;
    logic          rst_n;
    logic          sample_valid;
    logic [DW-1:0] enc1_data;
    logic [DW-1:0] enc2_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic [2:0]    fifo_level;
    logic [7:0]    drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]    rx_q [$];
    logic [DW-1:0] s_e1 [$];
    logic [DW-1:0] s_e2 [$];
    logic [7:0]    golden [7] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h0A, 8'hBC, 8'h90};

    enc_frame_packer #(.DW(DW), .FIFO_DEPTH(DEPTH), .HEADER(HEADER)) dut (
        .CLK_10MHZ    (clk),
        .RST_N        (rst_n),
        .sample_valid (sample_valid),
        .enc1_data    (enc1_data),
        .enc2_data    (enc2_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Host UART: takes a byte on every handshake edge.
    always @(posedge clk) begin
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 20 ms");
        $fatal(1);
    end

    // Expected byte i of the frame for the k-th sample since reset.
    function automatic logic [7:0] fbyte(input int k, input int i);
        int a, b;
        int v [7];
        a = int'(s_e1[k]);
        b = int'(s_e2[k]);
        v[0] = int'(HEADER);
        v[1] = k % 256;
        v[2] = a / 256;
        v[3] = a % 256;
        v[4] = b / 256;
        v[5] = b % 256;
        v[6] = v[1] ^ v[2] ^ v[3] ^ v[4] ^ v[5];
        return 8'(v[i]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        tx_ready     = 1'b0;
        enc1_data    = '0;
        enc2_data    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        rx_q.delete();
        s_e1.delete();
        s_e2.delete();
    endtask

    task automatic strobe(input logic [DW-1:0] a, input logic [DW-1:0] b);
        sample_valid = 1'b1;
        enc1_data    = a;
        enc2_data    = b;
        s_e1.push_back(a);
        s_e2.push_back(b);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic strobe_rand();
        strobe(DW'($urandom), DW'($urandom));
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b tx_valid=%b, required idle within 3000 cycles", busy, tx_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || fifo_level !== 3'd0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b data=%h busy=%b level=%0d drops=%0d, required all 0",
                     tx_valid, tx_data, busy, fifo_level, drop_cnt);
        end
        for (int i = 0; i < 7; i++) strobe_rand();
        n_tests++;
        if (drop_cnt !== 8'd2 || fifo_level !== 3'd4) begin
            n_fail++;
            $display("FAIL reset_precond: drops=%0d level=%0d, required 2 and 4", drop_cnt, fifo_level);
        end
        #20;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || fifo_level !== 3'd0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b data=%h busy=%b level=%0d drops=%0d, required all 0 at once",
                     tx_valid, tx_data, busy, fifo_level, drop_cnt);
        end
        do_reset();
        tx_ready = 1'b1;
        strobe_rand();
        drain();
        n_tests++;
        if (rx_q.size() !== 7 || rx_q[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_first_seq: bytes=%0d seq=%h, required 7 bytes seq 00", rx_q.size(), rx_q[1]);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        tx_ready = 1'b1;
        strobe(13'h1234, 13'h0ABC);
        n_tests++;
        if (tx_valid !== 1'b0 || fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_c1: valid=%b level=%0d, required 0 and 1", tx_valid, fifo_level);
        end
        tick();
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== golden[i]) begin
                n_fail++;
                $display("FAIL single_byte%0d: valid=%b data=%h, required 1 %h", i, tx_valid, tx_data, golden[i]);
            end
            tick();
        end
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: valid=%b busy=%b, required 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        tx_ready = 1'b1;
        strobe(13'h1234, 13'h0ABC);
        for (int c = 0; c < 10; c++) begin
            if (tx_valid && tx_data == 8'h34) break;
            tick();
        end
        tx_ready = 1'b0;
        n_tests++;
        if (rx_q.size() !== 3) begin
            n_fail++;
            $display("FAIL bp_before_stall: bytes=%0d, required 3", rx_q.size());
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h, required 1 34", c, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        drain();
        bad = 0;
        for (int i = 0; i < 7 && i < rx_q.size(); i++) if (rx_q[i] !== golden[i]) bad++;
        n_tests++;
        if (rx_q.size() !== 7 || bad != 0) begin
            n_fail++;
            $display("FAIL bp_frame: bytes=%0d wrong=%0d, required 7 bytes A5 00 12 34 0A BC 90", rx_q.size(), bad);
        end
    endtask

    task automatic test_overflow();
        int gaps, bad;
        do_reset();
        for (int i = 0; i < 6; i++) strobe_rand();
        n_tests++;
        if (fifo_level !== 3'd4 || drop_cnt !== 8'd1 || tx_valid !== 1'b1 || tx_data !== HEADER) begin
            n_fail++;
            $display("FAIL ovf_state: level=%0d drops=%0d valid=%b data=%h, required 4 1 1 a5",
                     fifo_level, drop_cnt, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        gaps = 0;
        for (int c = 0; c < 60 && rx_q.size() < 35; c++) begin
            if (tx_valid !== 1'b1) gaps++;
            tick();
        end
        n_tests++;
        if (gaps != 0) begin
            n_fail++;
            $display("FAIL ovf_gaps: gaps=%0d, required 0", gaps);
        end
        bad = 0;
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < 7; i++)
                if (7*f+i >= rx_q.size() || rx_q[7*f+i] !== fbyte(f, i)) bad++;
        n_tests++;
        if (rx_q.size() !== 35 || bad != 0) begin
            n_fail++;
            $display("FAIL ovf_frames: bytes=%0d wrong=%0d, required 35 bytes seq 0..4", rx_q.size(), bad);
        end
        drain();
        strobe_rand();
        drain();
        n_tests++;
        if (rx_q.size() !== 42 || rx_q[36] !== 8'h06) begin
            n_fail++;
            $display("FAIL ovf_next_seq: bytes=%0d seq=%h, required 42 bytes seq 06", rx_q.size(), rx_q[36]);
        end
    endtask

    task automatic test_collision();
        int bad;
        do_reset();
        for (int i = 0; i < 5; i++) strobe_rand();
        n_tests++;
        if (fifo_level !== 3'd4) begin
            n_fail++;
            $display("FAIL coll_fill: level=%0d, required 4", fifo_level);
        end
        tx_ready = 1'b1;
        for (int c = 0; c < 20 && rx_q.size() < 6; c++) tick();
        strobe_rand();
        n_tests++;
        if (drop_cnt !== 8'd0 || fifo_level !== 3'd4) begin
            n_fail++;
            $display("FAIL coll_push_pop: drops=%0d level=%0d, required 0 and 4", drop_cnt, fifo_level);
        end
        drain();
        bad = 0;
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 7; i++)
                if (7*f+i >= rx_q.size() || rx_q[7*f+i] !== fbyte(f, i)) bad++;
        n_tests++;
        if (rx_q.size() !== 42 || bad != 0) begin
            n_fail++;
            $display("FAIL coll_frames: bytes=%0d wrong=%0d, required 42 bytes seq 0..5", rx_q.size(), bad);
        end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        for (int i = 0; i < 256; i++) strobe_rand();
        n_tests++;
        if (drop_cnt !== 8'd251) begin
            n_fail++;
            $display("FAIL wrap_drops: drops=%0d, required 251", drop_cnt);
        end
        tx_ready = 1'b1;
        drain();
        strobe_rand();
        drain();
        n_tests++;
        if (rx_q.size() !== 42 || rx_q[36] !== 8'h00 || rx_q[41] !== fbyte(256, 6)) begin
            n_fail++;
            $display("FAIL wrap_seq: bytes=%0d seq=%h csum=%h, required 42 bytes seq 00 csum %h",
                     rx_q.size(), rx_q[36], rx_q[41], fbyte(256, 6));
        end
        do_reset();
        for (int i = 0; i < 260; i++) strobe_rand();
        n_tests++;
        if (drop_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_reach: drops=%0d, required 255", drop_cnt);
        end
        for (int i = 0; i < 45; i++) strobe_rand();
        n_tests++;
        if (drop_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_hold: drops=%0d, required 255", drop_cnt);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] prev_dat;
        bit         prev_stall, bad;
        int         frames, k, j, exp_drop;
        do_reset();
        prev_stall = 1'b0;
        prev_dat   = '0;
        for (int c = 0; c < 1500; c++) begin
            if (prev_stall) begin
                n_tests++;
                if (tx_valid !== 1'b1 || tx_data !== prev_dat) begin
                    n_fail++;
                    $display("FAIL rand_stall_hold c%0d: valid=%b data=%h, required 1 %h", c, tx_valid, tx_data, prev_dat);
                end
            end
            n_tests++;
            if (fifo_level > 3'd4) begin
                n_fail++;
                $display("FAIL rand_level c%0d: level=%0d, required <= 4", c, fifo_level);
            end
            tx_ready   = ($urandom_range(0, 1) == 1);
            prev_stall = tx_valid && !tx_ready;
            prev_dat   = tx_data;
            if ($urandom_range(0, 9) == 0) strobe_rand();
            else tick();
        end
        tx_ready = 1'b1;
        drain();
        n_tests++;
        if (rx_q.size() % 7 != 0) begin
            n_fail++;
            $display("FAIL rand_len: bytes=%0d, required a multiple of 7", rx_q.size());
        end
        frames = rx_q.size() / 7;
        k = 0;
        for (int f = 0; f < frames; f++) begin
            j = k;
            while (j < s_e1.size() && (j % 256) != int'(rx_q[7*f+1])) j++;
            bad = (j >= s_e1.size());
            if (!bad) for (int i = 0; i < 7; i++) if (rx_q[7*f+i] !== fbyte(j, i)) bad = 1'b1;
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL rand_frame%0d: seq=%h not a correct in-order frame of a sent sample", f, rx_q[7*f+1]);
            end
            if (j < s_e1.size()) k = j + 1;
        end
        exp_drop = s_e1.size() - frames;
        if (exp_drop > 255) exp_drop = 255;
        n_tests++;
        if (drop_cnt !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL rand_drops: drops=%0d, required %0d", drop_cnt, exp_drop);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_collision();
        test_wrap_saturate();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
